// File: rtl/lbp_hist.sv
// rtl/lbp_hist.sv - 256-bin LBP code histogram with mode tracking and valid/ready bin readout
module lbp_hist #(
  parameter int ADDR_W         = 14,
  parameter int CNT_W          = 15,
  parameter bit EXCLUDE_BORDER = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [7:0]        lbp_data,
  input  logic              finish,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [7:0]        hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic [ADDR_W:0]   total_cnt,
  output logic [7:0]        mode_bin,
  output logic [CNT_W-1:0]  mode_cnt,
  output logic              hist_done,
  output logic              drop_err
);

  // Image is 128 columns wide; the row occupies the remaining upper address bits.
  localparam int COL_W = 7;
  localparam int ROW_W = ADDR_W - COL_W;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_READOUT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   count_q [256];
  logic               hist_valid_q;
  logic [7:0]         hist_bin_q;
  logic [CNT_W-1:0]   hist_count_q;
  logic [ADDR_W:0]    total_cnt_q;
  logic [7:0]         mode_bin_q;
  logic [CNT_W-1:0]   mode_cnt_q;
  logic               hist_done_q;
  logic               drop_err_q;

  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic               interior;
  logic               count_en;
  logic [CNT_W-1:0]   inc_val;
  logic               mode_take;
  logic [CNT_W-1:0]   cnt0_next;
  logic [7:0]         next_bin;

  // Classify the incoming beat and precompute the incremented bin value used by
  // the counter, the mode tracker and the bin-0 readout preload.
  always_comb begin
    row       = lbp_addr[ADDR_W-1:COL_W];
    col       = lbp_addr[COL_W-1:0];
    interior  = (row != '0) && (row != '1) && (col != '0) && (col != '1);
    count_en  = (state_q == ST_ACCUM) && lbp_valid &&
                (interior || (EXCLUDE_BORDER == 1'b0));
    inc_val   = count_q[lbp_data] + CNT_W'(1);
    mode_take = count_en &&
                ((inc_val > mode_cnt_q) ||
                 ((inc_val == mode_cnt_q) && (lbp_data < mode_bin_q)));
    cnt0_next = (count_en && (lbp_data == 8'd0)) ? inc_val : count_q[0];
    next_bin  = hist_bin_q + 8'd1;
  end

  // Bin counters: one read-modify-write per cycle, so back-to-back hits on the
  // same bin never lose an increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        count_q[i] <= '0;
      end
    end else if (count_en) begin
      count_q[lbp_data] <= inc_val;
    end
  end

  // Control FSM with registered readout, summary and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ACCUM;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= 8'd0;
      hist_count_q <= '0;
      total_cnt_q  <= '0;
      mode_bin_q   <= 8'd0;
      mode_cnt_q   <= '0;
      hist_done_q  <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      if (lbp_valid && (state_q != ST_ACCUM)) begin
        drop_err_q <= 1'b1;
      end
      case (state_q)
        ST_ACCUM: begin
          if (count_en) begin
            total_cnt_q <= total_cnt_q + (ADDR_W+1)'(1);
          end
          if (mode_take) begin
            mode_bin_q <= lbp_data;
            mode_cnt_q <= inc_val;
          end
          if (finish) begin
            state_q      <= ST_READOUT;
            hist_valid_q <= 1'b1;
            hist_bin_q   <= 8'd0;
            hist_count_q <= cnt0_next;
          end
        end
        ST_READOUT: begin
          if (hist_ready) begin
            if (hist_bin_q == 8'hFF) begin
              state_q      <= ST_DONE;
              hist_valid_q <= 1'b0;
              hist_done_q  <= 1'b1;
            end else begin
              hist_bin_q   <= next_bin;
              hist_count_q <= count_q[next_bin];
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_ACCUM;
        end
      endcase
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_count = hist_count_q;
  assign total_cnt  = total_cnt_q;
  assign mode_bin   = mode_bin_q;
  assign mode_cnt   = mode_cnt_q;
  assign hist_done  = hist_done_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// tb/tb_lbp_hist.sv - scoreboard bench for lbp_hist, border-excluding and all-pixel instances in lockstep
module tb_lbp_hist;

  logic        clk = 1'b0;
  logic        reset;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_ready;

  logic        hv0, hv1, hd0, hd1, de0, de1;
  logic [7:0]  hb0, hb1, mb0, mb1;
  logic [14:0] hc0, hc1, mc0, mc1;
  logic [14:0] tot0, tot1;

  lbp_hist #(.ADDR_W(14), .CNT_W(15), .EXCLUDE_BORDER(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .hist_valid(hv0), .hist_ready(hist_ready),
    .hist_bin(hb0), .hist_count(hc0), .total_cnt(tot0), .mode_bin(mb0),
    .mode_cnt(mc0), .hist_done(hd0), .drop_err(de0)
  );

  lbp_hist #(.ADDR_W(14), .CNT_W(15), .EXCLUDE_BORDER(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .hist_valid(hv1), .hist_ready(hist_ready),
    .hist_bin(hb1), .hist_count(hc1), .total_cnt(tot1), .mode_bin(mb1),
    .mode_cnt(mc1), .hist_done(hd1), .drop_err(de1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bin;
    logic [14:0] c0;
    logic [14:0] c1;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  int checks = 0;
  int errors = 0;
  int m0[256];
  int m1[256];
  int t0, t1;
  bit fin_seen, drop_exp;
  int exp_tot[2], exp_mb[2], exp_mc[2];
  int rdy_mode = 0;
  int rc = 0;
  int acc_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_interior(input int a);
    int r, c;
    r = a / 128;
    c = a % 128;
    return (r >= 1) && (r <= 126) && (c >= 1) && (c <= 126);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      m0[i] = 0;
      m1[i] = 0;
    end
    t0 = 0;
    t1 = 0;
    fin_seen = 0;
    drop_exp = 0;
    acc_cnt = 0;
    q.delete();
  endtask

  // Mode as the first maximum of a full scan; readout expectations queued per bin.
  task automatic finalize();
    int best0, best1, bb0, bb1;
    exp_t e;
    best0 = 0; best1 = 0; bb0 = 0; bb1 = 0;
    for (int b = 0; b < 256; b++) begin
      if (m0[b] > best0) begin best0 = m0[b]; bb0 = b; end
      if (m1[b] > best1) begin best1 = m1[b]; bb1 = b; end
    end
    exp_tot[0] = t0; exp_tot[1] = t1;
    exp_mb[0] = bb0; exp_mb[1] = bb1;
    exp_mc[0] = best0; exp_mc[1] = best1;
    for (int b = 0; b < 256; b++) begin
      e.bin = 8'(b);
      e.c0  = 15'(m0[b]);
      e.c1  = 15'(m1[b]);
      q.push_back(e);
    end
    fin_seen = 1;
  endtask

  task automatic beat(input int a, input int code, input bit fin);
    lbp_valid = 1'b1;
    lbp_addr  = 14'(a);
    lbp_data  = 8'(code);
    finish    = fin;
    if (fin_seen) begin
      drop_exp = 1;
    end else begin
      m1[code]++;
      t1++;
      if (is_interior(a)) begin
        m0[code]++;
        t0++;
      end
    end
    if (fin && !fin_seen) finalize();
    @(posedge clk); #1;
    lbp_valid = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_finish();
    finish = 1'b1;
    if (!fin_seen) finalize();
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lbp_valid = 1'b0;
    finish = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic rand_image(input int n, input int code_max);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      beat($urandom_range(0, 16383), $urandom_range(0, code_max), 1'b0);
    end
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!hd0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!hd0) begin
      checks++;
      errors++;
      $display("FAIL %s: hist_done not seen within %0d cycles", name, n);
    end else if (exp_cycles >= 0) begin
      chk(name, n, exp_cycles);
    end
  endtask

  task automatic end_check(input string tag);
    chk({tag, "_queue_left"}, q.size(), 0);
    chk({tag, "_accepted"}, acc_cnt, 256);
    chk({tag, "_drop0"}, de0, drop_exp);
    chk({tag, "_drop1"}, de1, drop_exp);
    chk({tag, "_done1"}, hd1, 1);
    idle(3);
    chk({tag, "_valid_after_done"}, hv0, 0);
    chk({tag, "_done_sticky"}, hd0, 1);
  endtask

  // Sink ready generator: always-ready, 1,0,0,1 pattern, or random.
  initial begin
    hist_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: hist_ready = 1'b1;
        1: hist_ready = ((rc % 4) == 0) || ((rc % 4) == 3);
        default: hist_ready = 1'($urandom_range(0, 1));
      endcase
      rc++;
    end
  end

  // Monitor: pops the scoreboard on every accepted bin and checks stall stability.
  logic [7:0]  pb0, pb1;
  logic [14:0] pc0, pc1;
  bit          pstall = 0;

  always @(negedge clk) begin
    if (reset) begin
      pstall = 0;
    end else begin
      if (pstall) begin
        chk("stall_bin0", hb0, pb0);
        chk("stall_cnt0", hc0, pc0);
        chk("stall_bin1", hb1, pb1);
        chk("stall_cnt1", hc1, pc1);
      end
      if (hv0 && hist_ready) begin
        acc_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: bin %0d presented with empty scoreboard", hb0);
        end else begin
          e_mon = q.pop_front();
          chk("bin0", hb0, e_mon.bin);
          chk("count0", hc0, e_mon.c0);
          chk("valid1", hv1, 1);
          chk("bin1", hb1, e_mon.bin);
          chk("count1", hc1, e_mon.c1);
          chk("total0", tot0, exp_tot[0]);
          chk("mode_bin0", mb0, exp_mb[0]);
          chk("mode_cnt0", mc0, exp_mc[0]);
          chk("total1", tot1, exp_tot[1]);
          chk("mode_bin1", mb1, exp_mb[1]);
          chk("mode_cnt1", mc1, exp_mc[1]);
        end
      end
      pstall = hv0 && !hist_ready;
      pb0 = hb0; pc0 = hc0; pb1 = hb1; pc1 = hc1;
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    lbp_valid = 1'b0;
    lbp_addr = '0;
    lbp_data = '0;
    finish = 1'b0;
    idle(2);
    do_reset();

    chk("rst_valid", {hv1, hv0}, 0);
    chk("rst_bin", {hb1, hb0}, 0);
    chk("rst_count", {hc1, hc0}, 0);
    chk("rst_total", {tot1, tot0}, 0);
    chk("rst_mode", {mb1, mb0, mc0[7:0]}, 0);
    chk("rst_status", {hd1, hd0, de1, de0}, 0);

    // Full image, every code 0.
    rdy_mode = 0;
    for (int a = 0; a < 16384; a++) beat(a, 0, 1'b0);
    do_finish();
    wait_done("full_done_latency", 256);
    chk("full_total0", tot0, 15876);
    chk("full_mode_cnt0", mc0, 15876);
    chk("full_mode_bin0", mb0, 0);
    chk("full_total1", tot1, 16384);
    end_check("full");

    // Border filter.
    do_reset();
    beat(0, 5, 1'b0);
    beat(127, 5, 1'b0);
    beat(128, 5, 1'b0);
    beat(129, 7, 1'b0);
    beat(16383, 5, 1'b0);
    do_finish();
    wait_done("border_done", -1);
    chk("border_total0", tot0, 1);
    chk("border_total1", tot1, 5);
    end_check("border");

    // Mode tie with back-to-back same-bin beats.
    do_reset();
    beat(129, 9, 1'b0);
    beat(130, 9, 1'b0);
    beat(131, 3, 1'b0);
    beat(132, 3, 1'b0);
    do_finish();
    wait_done("tie_done", -1);
    chk("tie_mode_bin", mb0, 3);
    chk("tie_mode_cnt", mc0, 2);
    end_check("tie");

    // Backpressure pattern 1,0,0,1.
    do_reset();
    rand_image(300, 15);
    rdy_mode = 1;
    do_finish();
    wait_done("bp_done", -1);
    end_check("bp");
    rdy_mode = 0;

    // Beat in the finish cycle counts, the following beat is dropped.
    do_reset();
    rand_image(20, 7);
    beat(200, 4, 1'b1);
    beat(300, 4, 1'b0);
    wait_done("overlap_done", -1);
    chk("overlap_drop", de0, 1);
    end_check("overlap");

    // Reset in the middle of readout, then a fresh image.
    do_reset();
    rand_image(200, 31);
    rdy_mode = 2;
    do_finish();
    beat(129, 1, 1'b0);
    n = 0;
    while (!(hv0 && hb0 == 8'd100) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(hv0 && hb0 == 8'd100)) begin
      checks++;
      errors++;
      $display("FAIL midrst_reach_bin100: bin 100 not presented within %0d cycles", n);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", {hv1, hv0}, 0);
    chk("midrst_done", {hd1, hd0}, 0);
    chk("midrst_drop", {de1, de0}, 0);
    chk("midrst_total", tot0, 0);
    chk("midrst_mode_cnt", mc0, 0);
    reset = 1'b0;
    model_clear();
    rand_image(400, 255);
    do_finish();
    wait_done("midrst_fresh_done", -1);
    end_check("midrst_fresh");
    rdy_mode = 0;

    // Randomised images with varied code ranges, ready behaviour and late beats.
    for (int it = 0; it < 3; it++) begin
      do_reset();
      rdy_mode = it % 3;
      rand_image(500, (it == 0) ? 3 : ((it == 1) ? 63 : 255));
      do_finish();
      if (it != 0) beat($urandom_range(0, 16383), $urandom_range(0, 255), 1'b0);
      wait_done("rand_done", -1);
      end_check("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP stage. Snoops that stage's result-write bus (lbp_valid/lbp_addr/lbp_data/finish) for a 128x128 image.
- Builds a 256-bin histogram of LBP codes, excluding border pixels by default.
- After the LBP stage signals finish, streams the histogram out bin by bin over a valid/ready handshake. Also reports total count, mode bin and mode count.

Parameters:
- ADDR_W, 14, pixel address width (row = addr[13:7], col = addr[6:0]).
- CNT_W, 15, per-bin counter width; 16384 pixels fit without overflow.
- EXCLUDE_BORDER, 1, when 1, codes at row/col 0 or 127 are not counted.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- lbp_valid  in  1  LBP result valid this cycle.
- lbp_addr  in  ADDR_W  pixel address of the result.
- lbp_data  in  8  LBP code = bin index.
- finish  in  1  LBP stage done; level or pulse.
- hist_valid  out  1  hist_bin/hist_count valid.
- hist_ready  in  1  sink accepts the current bin.
- hist_bin  out  8  bin index being presented.
- hist_count  out  CNT_W  count for hist_bin.
- total_cnt  out  ADDR_W+1  number of codes counted.
- mode_bin  out  8  bin with the highest count; lowest index wins ties.
- mode_cnt  out  CNT_W  count of mode_bin.
- hist_done  out  1  sticky; readout of all 256 bins complete.
- drop_err  out  1  sticky; lbp_valid seen after finish.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. Reset takes priority over all other activity, including mid-readout.
- Reset values: all 256 counters = 0; total_cnt = 0; mode_bin = 0; mode_cnt = 0; hist_valid = 0; hist_bin = 0; hist_count = 0; hist_done = 0; drop_err = 0; state = ACCUM.
- States: ACCUM -> READOUT -> DONE. DONE is exited only by reset.
- ACCUM counting:
  - A beat is counted when lbp_valid=1 and the address is interior (row and col both in 1..126), or when EXCLUDE_BORDER=0.
  - A counted beat increments count[lbp_data] and total_cnt on the next edge.
  - One beat per cycle. Back-to-back beats to the same bin each count (no lost increments).
- Mode tracking (same edge as the increment): new = count[b]+1. Update mode if new > mode_cnt, or new == mode_cnt and b < mode_bin.
- ACCUM -> READOUT: on the first edge with finish=1. A valid beat in that same cycle is still counted. Entering READOUT sets hist_valid=1, hist_bin=0, hist_count=count[0] (including any same-cycle increment).
- READOUT handshake:
  - While hist_valid=1 and hist_ready=0, hist_bin and hist_count hold stable.
  - On hist_valid and hist_ready, advance to the next bin on the next edge. There are no bubbles, so sustained ready gives 256 beats in 256 cycles.
- READOUT -> DONE: when bin 255 is accepted. On the next edge hist_valid=0 and hist_done=1.
- After finish: lbp_valid=1 in READOUT or DONE is ignored (no count change) and sets drop_err. finish in READOUT/DONE has no effect.
- total_cnt, mode_bin and mode_cnt are valid from READOUT entry and frozen thereafter.
- Width rules: counters do not saturate, since CNT_W covers the 2^ADDR_W max. total_cnt is ADDR_W+1 bits so 16384 is representable.

Test Plan:
- Full interior stream: 16384 beats, addr 0..16383, all code 8'h00, finish, hist_ready=1. Required: bin0=15876, bins 1..255=0, total_cnt=15876, mode_bin=0, mode_cnt=15876, hist_done 256 cycles after READOUT entry.
- Border filter: beats at addr 0, 127, 128, 129, 16383 with codes 5,5,5,7,5. Required: only addr 129 counted; bin7=1, bin5=0, total_cnt=1. With EXCLUDE_BORDER=0: bin5=4, bin7=1, total_cnt=5.
- Mode tie and back-to-back: interior codes 9,9,3,3 on consecutive cycles. Required: bin9=2, bin3=2, mode_bin=3, mode_cnt=2.
- Backpressure: hist_ready toggling 1,0,0,1 during readout. Required: hist_bin/hist_count stable while stalled, no bin skipped or repeated, 256 accepted beats, then hist_done=1.
- Finish overlap and late data: valid interior beat (code 4) in the finish cycle, then another valid beat one cycle later. Required: bin4=1, drop_err=1, counts unchanged by the late beat.
- Reset mid-readout: assert reset at bin 100 for one cycle. Required: next cycle all counters 0, hist_valid=0, hist_done=0, drop_err=0, state ACCUM; a fresh image then counts correctly.
